rv_spi_target: RTL and testbench

SPI responder (target) for the rv32 peripheral bus, mode 0 (CPOL=0, CPHA=0), MSB first. It is the far end of the existing SPI initiator, so an rv32emc board can act as an SPI peripheral to another controller. All external SPI pins are oversampled in the single system clock domain. The bus side sees a 16-deep TX FIFO, a 16-deep RX FIFO, status/control registers and a level interrupt.

---
 rtl/rv_spi_pkg.sv | 33 +++
 rtl/rv_spi_target_if.sv | 27 ++
 rtl/rv_spit_fifo.sv | 67 ++++++
 rtl/rv_spi_target.sv | 260 ++++++++++++++++++++++++++
 tb/tb_rv_spi_target.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_spi_pkg.sv
// rtl/rv_spi_pkg.sv - shared types, register indices and engine state for the SPI target
package rv_spi_pkg;

    typedef logic [7:0]  u8_t;
    typedef logic [4:0]  u5_t;
    typedef logic [31:0] u32_t;

    // Register index, taken from adr[4:2].
    localparam logic [2:0] SPIT_CTRL = 3'd0;
    localparam logic [2:0] SPIT_RXD  = 3'd1;

    // Bit positions inside the CTRL/status read word.
    localparam int ST_SCS       = 0;
    localparam int ST_TX_OVF    = 1;
    localparam int ST_TX_UNF    = 2;
    localparam int ST_RX_OVF    = 3;
    localparam int ST_BUSY      = 4;
    localparam int ST_THR_LSB   = 8;
    localparam int ST_TXCNT_LSB = 16;
    localparam int ST_RXCNT_LSB = 24;

    // Bit positions inside the CTRL write word.
    localparam int CW_TX_FLUSH  = 8;
    localparam int CW_RX_FLUSH  = 9;
    localparam int CW_CLR       = 10;
    localparam int CW_THR_LSB   = 16;

    typedef enum logic {
        ENG_IDLE   = 1'b0,
        ENG_ACTIVE = 1'b1
    } eng_state_t;

endpackage

// File: rtl/rv_spi_target_if.sv
// rtl/rv_spi_target_if.sv - rv32 peripheral bus bundle for the SPI target
//   adr : byte address, adr[4:2] selects the register
//   cs  : block select        rdy : bus advance (accesses qualify on cs&&rdy)
//   we  : byte write enables  re  : read strobe
//   dw  : write data          dr  : registered read data (driven by the target)
interface rv_spi_target_if;
    import rv_spi_pkg::*;

    logic [4:0] adr;
    logic       cs;
    logic       rdy;
    logic [3:0] we;
    logic       re;
    u32_t       dw;
    u32_t       dr;

    modport master (
        output adr, cs, rdy, we, re, dw,
        input  dr
    );

    modport slave (
        input  adr, cs, rdy, we, re, dw,
        output dr
    );

endinterface

// File: rtl/rv_spit_fifo.sv
// rtl/rv_spit_fifo.sv - synchronous byte FIFO used for the TX and RX queues
//   clk, xreset : clock, asynchronous active-low reset
//   push, din   : write request and data (accepted when not full, or full with a pop)
//   pop, dout   : read request and head-of-queue data
//   flush       : empties the FIFO, takes priority over push/pop
//   full, empty, count : occupancy, count ranges 0..DEPTH
module rv_spit_fifo
    import rv_spi_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     xreset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  u8_t                      din,
    output u8_t                      dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    u8_t             mem [DEPTH];
    logic [AW-1:0]   wp;
    logic [AW-1:0]   rp;
    logic [CW-1:0]   cnt;
    logic            do_push;
    logic            do_pop;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    assign dout  = mem[rp];

    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wp] <= din;
    end

endmodule

// File: rtl/rv_spi_target.sv
// rtl/rv_spi_target.sv - mode 0 SPI target with TX/RX FIFOs on the rv32 peripheral bus
//   clk, xreset : system clock (>= 8x sck), asynchronous active-low reset
//   bus         : peripheral bus slave (adr/cs/rdy/we/re/dw/dr)
//   sck, scs, sdi : SPI pins from the initiator, oversampled in clk
//   sdo, sdo_oe : MISO data and its output enable
//   irq         : level interrupt (RX threshold, RX overflow, TX underflow)
module rv_spi_target
    import rv_spi_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int SYNC  = 2
) (
    input  logic                  clk,
    input  logic                  xreset,
    rv_spi_target_if.slave        bus,
    input  logic                  sck,
    input  logic                  scs,
    input  logic                  sdi,
    output logic                  sdo,
    output logic                  sdo_oe,
    output logic                  irq
);

    localparam int CW = $clog2(DEPTH) + 1;

    // ---------------------------------------------------------------
    // Pin synchronizers and edge detection
    // ---------------------------------------------------------------
    logic [SYNC-1:0] sck_sy, scs_sy, sdi_sy;
    logic            sck_d, scs_d;
    logic            sck_s, scs_s, sdi_s;
    logic            sck_r, sck_f, scs_f, scs_r;

    // scs resets high so the block comes out of reset deselected with no edge.
    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            sck_sy <= '0;
            scs_sy <= '1;
            sdi_sy <= '0;
            sck_d  <= 1'b0;
            scs_d  <= 1'b1;
        end else begin
            sck_sy <= {sck_sy[SYNC-2:0], sck};
            scs_sy <= {scs_sy[SYNC-2:0], scs};
            sdi_sy <= {sdi_sy[SYNC-2:0], sdi};
            sck_d  <= sck_sy[SYNC-1];
            scs_d  <= scs_sy[SYNC-1];
        end
    end

    assign sck_s = sck_sy[SYNC-1];
    assign scs_s = scs_sy[SYNC-1];
    assign sdi_s = sdi_sy[SYNC-1];

    assign sck_r =  sck_s && !sck_d;
    assign sck_f = !sck_s &&  sck_d;
    assign scs_f = !scs_s &&  scs_d;
    assign scs_r =  scs_s && !scs_d;

    // ---------------------------------------------------------------
    // FIFOs
    // ---------------------------------------------------------------
    logic           tx_push, tx_pop, tx_flush, tx_full, tx_empty;
    logic           rx_push, rx_pop, rx_flush, rx_full, rx_empty;
    u8_t            tx_head, rx_head, rx_din;
    logic [CW-1:0]  tx_cnt, rx_cnt;

    rv_spit_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk    (clk),
        .xreset (xreset),
        .push   (tx_push),
        .pop    (tx_pop),
        .flush  (tx_flush),
        .din    (bus.dw[7:0]),
        .dout   (tx_head),
        .full   (tx_full),
        .empty  (tx_empty),
        .count  (tx_cnt)
    );

    rv_spit_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk    (clk),
        .xreset (xreset),
        .push   (rx_push),
        .pop    (rx_pop),
        .flush  (rx_flush),
        .din    (rx_din),
        .dout   (rx_head),
        .full   (rx_full),
        .empty  (rx_empty),
        .count  (rx_cnt)
    );

    // ---------------------------------------------------------------
    // Engine FSM
    // ---------------------------------------------------------------
    eng_state_t state, state_nx;
    logic [2:0] bitcnt;
    logic       byte_done;
    u8_t        rxsh, txsh;
    logic       busy;
    logic       tx_load, tx_shift, rx_shift, byte_end;

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) state <= ENG_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ENG_IDLE:   if (scs_f) state_nx = ENG_ACTIVE;
            ENG_ACTIVE: if (scs_r) state_nx = ENG_IDLE;
            default:    state_nx = ENG_IDLE;
        endcase
    end

    // scs_r suppresses any sck event in the same cycle, so a byte that
    // completes exactly as the frame ends is never pushed.
    always_comb begin
        busy     = (state == ENG_ACTIVE);
        tx_load  = 1'b0;
        tx_shift = 1'b0;
        rx_shift = 1'b0;
        byte_end = 1'b0;
        case (state)
            ENG_IDLE: tx_load = scs_f;
            ENG_ACTIVE: begin
                if (!scs_r) begin
                    if (sck_r) begin
                        rx_shift = 1'b1;
                        byte_end = (bitcnt == 3'd7);
                    end else if (sck_f) begin
                        tx_load  = byte_done;
                        tx_shift = !byte_done;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            bitcnt    <= 3'd0;
            byte_done <= 1'b0;
            rxsh      <= '0;
            txsh      <= '0;
        end else begin
            if (state == ENG_IDLE && scs_f) begin
                bitcnt    <= 3'd0;
                byte_done <= 1'b0;
            end else if (state == ENG_ACTIVE && scs_r) begin
                bitcnt    <= 3'd0;
                byte_done <= 1'b0;
                rxsh      <= '0;
            end else if (rx_shift) begin
                rxsh   <= {rxsh[6:0], sdi_s};
                bitcnt <= bitcnt + 3'd1;
                if (byte_end) byte_done <= 1'b1;
            end else if (tx_load) begin
                byte_done <= 1'b0;
            end

            // The next TX byte replaces txsh on the fall after a full byte,
            // so its MSB is on sdo before the initiator's next rising edge.
            if (tx_load)       txsh <= tx_empty ? 8'h00 : tx_head;
            else if (tx_shift) txsh <= {txsh[6:0], 1'b0};
        end
    end

    assign rx_din = {rxsh[6:0], sdi_s};
    assign sdo    = txsh[7];
    assign sdo_oe = !scs_s;

    // ---------------------------------------------------------------
    // Bus decode
    // ---------------------------------------------------------------
    logic        acc, wr_ctrl, clr;
    logic [2:0]  reg_sel;
    logic        tx_ovf, tx_unf, rx_ovf;
    logic        tx_ovf_set, tx_unf_set, rx_ovf_set;
    u5_t         rx_thr;
    u32_t        status, rd_mux;

    assign acc      = bus.cs && bus.rdy;
    assign reg_sel  = bus.adr[4:2];
    assign wr_ctrl  = acc && (reg_sel == SPIT_CTRL);

    assign tx_push  = wr_ctrl && bus.we[0];
    assign tx_pop   = tx_load && !tx_empty;
    assign tx_flush = wr_ctrl && bus.we[1] && bus.dw[CW_TX_FLUSH];
    assign rx_push  = byte_end;
    assign rx_pop   = acc && bus.re && (reg_sel == SPIT_RXD) && !rx_empty;
    assign rx_flush = wr_ctrl && bus.we[1] && bus.dw[CW_RX_FLUSH];
    assign clr      = wr_ctrl && bus.we[1] && bus.dw[CW_CLR];

    // Overflow only counts when the FIFO cannot absorb the byte this cycle.
    assign tx_ovf_set = tx_push && tx_full && !tx_pop;
    assign rx_ovf_set = rx_push && rx_full && !rx_pop;
    assign tx_unf_set = tx_load && tx_empty;

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            tx_ovf <= 1'b0;
            tx_unf <= 1'b0;
            rx_ovf <= 1'b0;
        end else if (clr) begin
            tx_ovf <= 1'b0;
            tx_unf <= 1'b0;
            rx_ovf <= 1'b0;
        end else begin
            if (tx_ovf_set) tx_ovf <= 1'b1;
            if (tx_unf_set) tx_unf <= 1'b1;
            if (rx_ovf_set) rx_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset)                   rx_thr <= '0;
        else if (wr_ctrl && bus.we[2]) rx_thr <= bus.dw[CW_THR_LSB +: 5];
    end

    always_comb begin
        status                        = '0;
        status[ST_SCS]                = scs_s;
        status[ST_TX_OVF]             = tx_ovf;
        status[ST_TX_UNF]             = tx_unf;
        status[ST_RX_OVF]             = rx_ovf;
        status[ST_BUSY]               = busy;
        status[ST_THR_LSB +: 5]       = rx_thr;
        status[ST_TXCNT_LSB +: 5]     = u5_t'(tx_cnt);
        status[ST_RXCNT_LSB +: 5]     = u5_t'(rx_cnt);
    end

    // An empty RXD read reports only the empty flag; the stale head is masked.
    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            SPIT_CTRL: rd_mux = status;
            SPIT_RXD:  rd_mux = {23'b0, rx_empty, rx_empty ? 8'h00 : rx_head};
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset)      bus.dr <= '0;
        else if (bus.rdy) bus.dr <= bus.cs ? rd_mux : '0;
    end

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) irq <= 1'b0;
        else         irq <= ((rx_thr != '0) && (u5_t'(rx_cnt) >= rx_thr)) || rx_ovf || tx_unf;
    end

    logic unused_bits;
    assign unused_bits = ^{bus.adr[1:0], bus.we[3], bus.dw[31:21], bus.dw[15:11],
                           rxsh[7]};

endmodule

// File: tb/tb_rv_spi_target.sv
// tb/tb_rv_spi_target.sv - scoreboard bench for rv_spi_target with a queue-based model
module tb_rv_spi_target;

    logic clk = 1'b0;
    logic xreset = 1'b0;
    logic sck = 1'b0;
    logic scs = 1'b1;
    logic sdi = 1'b0;
    wire  sdo, sdo_oe, irq;

    rv_spi_target_if bus();

    rv_spi_target #(.DEPTH(16), .SYNC(2)) dut (
        .clk    (clk),
        .xreset (xreset),
        .bus    (bus),
        .sck    (sck),
        .scs    (scs),
        .sdi    (sdi),
        .sdo    (sdo),
        .sdo_oe (sdo_oe),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_miso[$];
    logic [31:0] exp_rd[$];
    bit          m_txovf, m_txunf, m_rxovf;
    int          m_thr;
    logic [7:0]  fr[32];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        int v;
        v = (rx_q.size() << 24) | (tx_q.size() << 16) | (m_thr << 8) |
            (int'(m_rxovf) << 3) | (int'(m_txunf) << 2) | (int'(m_txovf) << 1) | 1;
        return v;
    endfunction

    function automatic logic m_irq();
        return (m_thr != 0 && rx_q.size() >= m_thr) || m_rxovf || m_txunf;
    endfunction

    task automatic model_reset();
        tx_q.delete();
        rx_q.delete();
        m_txovf = 0;
        m_txunf = 0;
        m_rxovf = 0;
        m_thr   = 0;
    endtask

    task automatic bus_cycle(input logic [4:0] a, input logic [3:0] w, input logic r,
                             input logic [31:0] d);
        @(negedge clk);
        bus.adr = a; bus.cs = 1'b1; bus.rdy = 1'b1; bus.we = w; bus.re = r; bus.dw = d;
        @(negedge clk);
        bus.cs = 1'b0; bus.rdy = 1'b0; bus.we = 4'b0; bus.re = 1'b0;
    endtask

    task automatic bus_wr(input logic [3:0] w, input logic [31:0] d);
        if (w[0]) begin
            if (tx_q.size() < 16) tx_q.push_back(d[7:0]);
            else m_txovf = 1;
        end
        if (w[1]) begin
            if (d[8])  tx_q.delete();
            if (d[9])  rx_q.delete();
            if (d[10]) begin m_txovf = 0; m_txunf = 0; m_rxovf = 0; end
        end
        if (w[2]) m_thr = int'(d[20:16]);
        bus_cycle(5'h00, w, 1'b0, d);
    endtask

    task automatic rd_ctrl();
        exp_rd.push_back(exp_status());
        bus_cycle(5'h00, 4'b0, 1'b1, 32'h0);
    endtask

    task automatic rd_data();
        if (rx_q.size() != 0) exp_rd.push_back({24'h0, rx_q.pop_front()});
        else                  exp_rd.push_back(32'h100);
        bus_cycle(5'h04, 4'b0, 1'b1, 32'h0);
    endtask

    task automatic chk_irq();
        repeat (2) @(negedge clk);
        chk("irq", {31'b0, irq}, {31'b0, m_irq()});
    endtask

    task automatic spi_start();
        @(negedge clk);
        scs = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            sdi = b[7-i];
            repeat (4) @(negedge clk);
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic spi_end();
        repeat (4) @(negedge clk);
        scs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // A frame of 'full' whole bytes plus 'part' bits of one more. Every whole
    // byte is followed by a falling sck, so 1+full TX bytes are consumed.
    task automatic run_frame(input int full, input int part, input bit thr_chk);
        logic [7:0] ld;
        for (int i = 0; i <= full; i++) begin
            if (tx_q.size() != 0) ld = tx_q.pop_front();
            else begin ld = 8'h00; m_txunf = 1; end
            if (i < full) exp_miso.push_back(ld);
        end
        for (int i = 0; i < full; i++) begin
            if (rx_q.size() < 16) rx_q.push_back(fr[i]);
            else m_rxovf = 1;
        end
        spi_start();
        for (int i = 0; i < full; i++) begin
            spi_bits(fr[i], 8);
            if (thr_chk && (i == 2 || i == 3)) begin
                repeat (4) @(negedge clk);
                chk($sformatf("irq_thr_byte%0d", i + 1), {31'b0, irq}, (i == 3) ? 32'd1 : 32'd0);
            end
        end
        if (part != 0) spi_bits(fr[full], part);
        spi_end();
    endtask

    // Bus read monitor.
    initial begin
        forever begin
            @(posedge clk);
            if (bus.cs && bus.rdy && bus.re) begin
                @(negedge clk);
                if (exp_rd.size() == 0) chk("rd_unexpected", bus.dr, 32'hxxxx_xxxx);
                else                    chk("rd_data", bus.dr, exp_rd.pop_front());
            end
        end
    end

    // MISO monitor: assembles whole bytes sampled on sck rise.
    initial begin
        logic [7:0] b;
        int nb;
        nb = 0;
        b  = 8'h00;
        forever begin
            @(posedge sck or posedge scs);
            if (scs) nb = 0;
            else begin
                b = {b[6:0], sdo};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    if (exp_miso.size() == 0) chk("miso_unexpected", {24'h0, b}, 32'hxxxx_xxxx);
                    else                      chk("miso", {24'h0, b}, {24'h0, exp_miso.pop_front()});
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.adr = '0; bus.cs = 1'b0; bus.rdy = 1'b0; bus.we = '0; bus.re = 1'b0; bus.dw = '0;
        model_reset();
        repeat (3) @(negedge clk);
        xreset = 1'b1;
        repeat (4) @(negedge clk);

        // Reset state.
        chk("rst_sdo", {31'b0, sdo}, 32'd0);
        chk("rst_sdo_oe", {31'b0, sdo_oe}, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        rd_ctrl();

        // Two-byte frame with queued TX data.
        bus_wr(4'b0001, 32'hA5);
        bus_wr(4'b0001, 32'h3C);
        fr[0] = 8'h12; fr[1] = 8'h34;
        run_frame(2, 0, 0);
        rd_ctrl();
        repeat (3) rd_data();
        bus_wr(4'b0010, 32'h400);
        chk_irq();

        // Frame with TX empty: underflow and irq, then sticky clear.
        fr[0] = 8'($urandom);
        run_frame(1, 0, 0);
        rd_ctrl();
        chk_irq();
        bus_wr(4'b0010, 32'h400);
        rd_ctrl();
        chk_irq();
        rd_data();

        // Flush both FIFOs.
        for (int i = 0; i < 3; i++) bus_wr(4'b0001, $urandom);
        bus_wr(4'b0010, 32'h300);
        rd_ctrl();

        // dr clears on an idle cycle with rdy high.
        @(negedge clk); bus.rdy = 1'b1;
        @(negedge clk); bus.rdy = 1'b0;
        chk("dr_idle_rdy", bus.dr, 32'h0);

        // Threshold and RX overflow with a 17-byte frame; 17 pushes overflow TX.
        for (int i = 0; i < 17; i++) bus_wr(4'b0001, $urandom);
        rd_ctrl();
        bus_wr(4'b0100, 32'd4 << 16);
        for (int i = 0; i < 17; i++) fr[i] = 8'($urandom);
        run_frame(17, 0, 1);
        rd_ctrl();
        chk_irq();
        for (int i = 0; i < 17; i++) rd_data();
        bus_wr(4'b0110, 32'h400);

        // Frame cut after 5 bits of byte 2, then a fresh frame realigns.
        fr[0] = 8'hC3; fr[1] = 8'hFF;
        run_frame(1, 5, 0);
        rd_ctrl();
        fr[0] = 8'h5A;
        run_frame(1, 0, 0);
        rd_data();
        rd_data();
        bus_wr(4'b0010, 32'h400);

        // Randomized frames.
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) bus_wr(4'b0001, $urandom);
            bus_wr(4'b0100, $urandom_range(0, 3) << 16);
            n = $urandom_range(1, 4);
            for (int i = 0; i <= n; i++) fr[i] = 8'($urandom);
            run_frame(n, $urandom_range(0, 7), 0);
            rd_ctrl();
            chk_irq();
            n = rx_q.size();
            for (int i = 0; i <= n; i++) rd_data();
            bus_wr(4'b0010, 32'h400);
        end

        // Reset in the middle of a frame.
        bus_wr(4'b0001, 32'hFF);
        rd_ctrl();
        spi_start();
        spi_bits(8'hFF, 3);
        @(negedge clk);
        xreset = 1'b0;
        #1;
        chk("midrst_dr", bus.dr, 32'h0);
        chk("midrst_sdo", {31'b0, sdo}, 32'd0);
        chk("midrst_sdo_oe", {31'b0, sdo_oe}, 32'd0);
        chk("midrst_irq", {31'b0, irq}, 32'd0);
        scs = 1'b1;
        repeat (2) @(negedge clk);
        xreset = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        rd_ctrl();
        rd_data();
        chk_irq();

        repeat (20) @(negedge clk);
        chk("leftover_rd", exp_rd.size(), 32'd0);
        chk("leftover_miso", exp_miso.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
